// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory read/write port between two requesters,
// with bounded burst locking and per-requester read-data return through the memory pipeline.
module mem_port_arbiter #(
  parameter int LATENCY   = 2,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [3:0]  r0_wen,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic        r0_lock,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic [3:0]  r1_wen,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic        r1_lock,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_raddr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic             r_last, r_locked, r_owner;
  logic [CW-1:0]    r_burst_cnt;
  logic [LATENCY-1:0] r_pv, r_pid;
  logic             w_g0, w_g1, w_any, w_id, w_lock, w_rd, w_hold;
  logic [3:0]       w_wen;
  always_comb begin
    w_g0   = !rst && r0_req && (r_locked ? !r_owner : (!r1_req || r_last));
    w_g1   = !rst && r1_req && (r_locked ? r_owner : (!r0_req || !r_last));
    w_any  = w_g0 || w_g1;
    w_id   = w_g1;
    w_wen  = w_id ? r1_wen : r0_wen;
    w_lock = w_id ? r1_lock : r0_lock;
    w_rd   = w_any && (w_wen == 4'd0);
    w_hold = w_any && w_lock && (32'(r_burst_cnt) + 1 < MAX_BURST);
  end
  assign r0_gnt    = w_g0;
  assign r1_gnt    = w_g1;
  assign mem_raddr = w_id ? r1_addr : r0_addr;
  assign mem_waddr = mem_raddr;
  assign mem_wdata = w_id ? r1_wdata : r0_wdata;
  assign mem_wen   = w_any ? w_wen : 4'd0;
  // The oldest pipeline stage lines up with the memory's rdata for the read it tracks.
  assign r0_rvalid = r_pv[LATENCY-1] && !r_pid[LATENCY-1];
  assign r1_rvalid = r_pv[LATENCY-1] && r_pid[LATENCY-1];
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= 1'b1;
      r_locked    <= 1'b0;
      r_owner     <= 1'b0;
      r_burst_cnt <= '0;
      r_pv        <= '0;
      r_pid       <= '0;
    end else begin
      if (w_any) r_last <= w_id;
      if (w_hold) r_owner <= w_id;
      r_locked    <= w_hold;
      r_burst_cnt <= w_hold ? r_burst_cnt + 1'b1 : '0;
      r_pv        <= (r_pv << 1) | LATENCY'(w_rd);
      r_pid       <= (r_pid << 1) | LATENCY'(w_id);
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the main memory's data-side read port (port 1) and its byte-enable write port between two requesters.
  - Requester 0: CPU data/memory stage.
  - Requester 1: DMA/debug loader.
- Grants at most one access per cycle using round-robin priority, with an optional bounded lock for bursts.
- Tracks reads in flight through the memory's fixed 2-cycle read pipeline and returns each read's data to the requester that issued it.

Parameters:
- LATENCY, 2, memory read latency in clock edges from address capture to valid rdata; must be ≥ 1.
- MAX_BURST, 8, maximum consecutive grants one requester may hold via lock; must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- r0_req  in  1  requester 0 access request
- r0_wen  in  4  byte write enables; 0 = read
- r0_addr  in  32  byte address
- r0_wdata  in  32  write data
- r0_lock  in  1  request to keep the grant next cycle
- r0_gnt  out  1  request accepted this cycle (combinational)
- r0_rvalid  out  1  read data valid
- r0_rdata  out  32  read data
- r1_*  same seven signals as r0_*, for requester 1
- mem_raddr  out  32  to memory raddr1
- mem_wen  out  4  to memory wen
- mem_waddr  out  32  to memory waddr
- mem_wdata  out  32  to memory wdata
- mem_rdata  in  32  from memory rdata1

Behaviour:
- Handshake
  - A requester holds req, wen, addr, wdata and lock stable until it sees gnt high.
  - A transfer occurs in any cycle where req && gnt.
  - Never more than one gnt high per cycle.
  - Both gnt outputs are 0 while rst is high.
- Arbitration state: last (1 bit), locked (1 bit), owner (1 bit), burst_cnt (clog2(MAX_BURST+1) bits). Reset values: last=1, locked=0, owner=0, burst_cnt=0.
  - Exactly one requesting, not locked: that requester is granted.
  - Both requesting, not locked: the requester != last is granted. Requester 0 therefore wins the first conflict after reset.
  - locked=1: only owner can be granted. The other requester waits even if owner drops req.
  - No requester: no grant; state is unchanged except that the lock clears.
  - On each grant: last <= granted id.
- Lock
  - Granted with lock=1 and burst_cnt+1 < MAX_BURST: locked <= 1, owner <= id, burst_cnt <= burst_cnt+1.
  - Otherwise: locked <= 0, burst_cnt <= 0.
  - A lock therefore yields at most MAX_BURST consecutive grants.
  - An owner cycle with req=0 releases the lock.
- Memory drive (combinational from the granted request)
  - mem_raddr = mem_waddr = granted addr.
  - mem_wdata = granted wdata.
  - mem_wen = granted wen.
  - With no grant: mem_wen = 0; address and data outputs are don't-care.
  - Only the memory's word index (addr[15:2]) is significant; upper address bits pass through unchanged.
- Read tracking
  - A shift pipeline of LATENCY stages, each holding {valid, id}.
  - Stage 0 loads {grant && wen==0, granted id} every edge.
- Read return
  - A read granted in cycle N gives rX_rvalid=1 for exactly one cycle, in cycle N+LATENCY.
  - In that cycle rX_rdata = mem_rdata.
  - The other requester's rvalid stays 0.
  - rdata is don't-care when rvalid=0; the bench checks it only when rvalid=1.
- Read-after-write: a write granted in cycle N is visible to a read granted in cycle N+1 or later. No forwarding is needed.
- Throughput: back-to-back reads from alternating requesters are allowed, one per cycle. Return order equals grant order.
- Writes produce no response.
- Reset
  - Reset values: pipeline valids=0 and all tracking state as listed above.
  - rvalid outputs read 0 in the cycle after rst is sampled.
  - Reads in flight at reset are dropped and never reported.

Test Plan:
- Single read: r0 writes 0xDEADBEEF to 0x100 with wen=4'hF in cycle 0. r0 reads 0x100 in cycle 1 → r0_gnt=1 in cycle 1; r0_rvalid=1 with r0_rdata=0xDEADBEEF in cycle 3; r1_rvalid stays 0.
- Byte write: word 0x200=0x11223344. r1 writes wdata 0xAABBCCDD with wen=4'b0010, then reads 0x200 → r1_rdata=0x1122CC44.
- Contention: both requesters hold read requests from cycle 0, with no lock → grants alternate r0, r1, r0, r1 starting at cycle 0. rvalids alternate starting cycle 2, each carrying the owner's word.
- Lock burst: MAX_BURST=8, r1 requests with lock=1 for 12 cycles while r0 requests continuously → r1 granted 8 consecutive cycles, then r0 granted, then arbitration resumes alternating.
- Reset mid-flight: r0 read granted in cycle 5, rst=1 in cycle 6 → no r0_rvalid in cycles 6–8. After rst, the first conflict is granted to r0.
- Idle: no req for 20 cycles → mem_wen=0 and both gnt/rvalid=0 every cycle.
